sweep_seq: RTL
==============

Name: sweep_seq

Overview:
- Frequency-sweep sequencer for the frequency response detector; sits directly upstream of the DDS core and drives its frequency word.
- Steps the frequency through n_points values. At each point it waits a settle time, then opens a measurement window of dwell length.
- After the window it holds until the downstream detector acknowledges the point, then advances.
- Supports single-shot and continuous sweeps and a synchronous abort.

Parameters:
- FWORD_WIDTH, 32, width of frequency words and step.
- CNT_WIDTH, 24, width of the settle and dwell counters.
- IDX_WIDTH, 16, width of the point count and index.

Ports:
- clk  in  1  single clock (DDS domain); all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- param_wen  in  1  latch all parameter inputs (honoured only in IDLE).
- f_start  in  FWORD_WIDTH  first frequency word.
- f_step  in  FWORD_WIDTH  per-point increment (unsigned, wraps mod 2^FWORD_WIDTH).
- n_points  in  IDX_WIDTH  number of points per sweep.
- settle_cycles  in  CNT_WIDTH  settle length minus 1.
- dwell_cycles  in  CNT_WIDTH  dwell length minus 1.
- continuous  in  1  1 = restart after the last point.
- start  in  1  single-cycle pulse; begin sweep.
- abort  in  1  single-cycle pulse; stop immediately.
- meas_ack  in  1  detector has consumed the current point.
- fword  out  FWORD_WIDTH  frequency word to the DDS.
- point_idx  out  IDX_WIDTH  index of the current point.
- busy  out  1  high in any state other than IDLE.
- meas_valid  out  1  high during DWELL.
- point_rdy  out  1  high during WAIT_ACK.
- sweep_done  out  1  one-cycle pulse at the end of each sweep.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - All outputs = 0.
  - Latched parameters = 0.
- Parameter latch: in IDLE, param_wen copies all parameter inputs into internal registers. param_wen is ignored in other states.
- States: IDLE, SETTLE, DWELL, WAIT_ACK.
- IDLE:
  - start && !abort && n_pts_l != 0 → SETTLE next cycle, with fword = f_start_l, point_idx = 0, counter = settle_l.
  - start with n_pts_l == 0 is ignored.
- SETTLE:
  - Counter decrements each cycle.
  - When the counter is 0 → DWELL, with counter = dwell_l.
  - Duration is exactly settle_l + 1 cycles.
- DWELL:
  - meas_valid = 1.
  - Counter decrements; at 0 → WAIT_ACK.
  - Duration is exactly dwell_l + 1 cycles.
- WAIT_ACK:
  - point_rdy = 1; the state holds indefinitely.
  - meas_ack is sampled only in this state and ignored elsewhere.
  - On meas_ack with point_idx != n_pts_l − 1:
    - point_idx += 1; fword += f_step_l (modulo wrap).
    - → SETTLE with counter = settle_l.
  - On meas_ack with point_idx == n_pts_l − 1:
    - sweep_done pulses in the next cycle.
    - If continuous_l: point_idx = 0, fword = f_start_l → SETTLE.
    - Otherwise: → IDLE; fword and point_idx hold their last values.
- Output timing:
  - busy, meas_valid and point_rdy are registered and reflect the state in the same cycle.
  - fword changes exactly on the cycle SETTLE is entered, never during DWELL.
- abort:
  - From any non-IDLE state → IDLE next cycle.
  - No sweep_done; fword and point_idx hold.
  - abort beats both meas_ack and start in the same cycle.
- Reset asserted mid-sweep: immediate return to reset values. No sweep_done.
- Arithmetic: fword is accumulated by addition, not multiplication; overflow wraps silently.

Test Plan:
- Reset, then param_wen with f_start=0x1000, f_step=0x100, n_points=3, settle=2, dwell=4, continuous=0; start pulse; meas_ack 1 cycle after each point_rdy rise → required:
  - fword sequence 0x1000, 0x1100, 0x1200.
  - Each point: SETTLE lasts 3 cycles, then meas_valid high for 5 cycles.
  - sweep_done pulses once; busy = 0 afterwards; fword stays 0x1200.
- Same parameters, meas_ack held low for 50 cycles → point_rdy stays high, point_idx and fword unchanged, no advance.
- continuous=1, n_points=2, f_start=0xFFFF_FF00, f_step=0x200 →
  - fword sequence 0xFFFF_FF00, 0x0000_0100 (wrap), then 0xFFFF_FF00.
  - sweep_done pulses after each second point.
- abort during DWELL of point 1 → IDLE next cycle, meas_valid = 0, no sweep_done, fword held. A new start then begins again at f_start.
- Edge cases:
  - param_wen while busy (new f_start) has no effect on the current sweep.
  - start with n_points=0 keeps busy at 0.
  - start and abort in the same cycle keeps the block in IDLE.
  - meas_ack pulsed during SETTLE is ignored.
- rst asserted asynchronously mid-SETTLE → all outputs 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/sweep_seq.sv
// Frequency-sweep sequencer feeding the DDS frequency word.
// Each point: settle, dwell (measurement window), then hold until the detector acks.
module sweep_seq #(
   parameter int FWORD_WIDTH = 32,
   parameter int CNT_WIDTH   = 24,
   parameter int IDX_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   param_wen,
   input  logic [FWORD_WIDTH-1:0] f_start,
   input  logic [FWORD_WIDTH-1:0] f_step,
   input  logic [IDX_WIDTH-1:0]   n_points,
   input  logic [CNT_WIDTH-1:0]   settle_cycles,
   input  logic [CNT_WIDTH-1:0]   dwell_cycles,
   input  logic                   continuous,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   meas_ack,
   output logic [FWORD_WIDTH-1:0] fword,
   output logic [IDX_WIDTH-1:0]   point_idx,
   output logic                   busy,
   output logic                   meas_valid,
   output logic                   point_rdy,
   output logic                   sweep_done
);

   // state    | meaning
   // S_IDLE   | parked; parameters may be latched
   // S_SETTLE | new frequency applied, waiting for DDS/analog settling
   // S_DWELL  | measurement window open
   // S_WAIT   | window closed, waiting for detector ack
   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DWELL, S_WAIT} state_t;

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [FWORD_WIDTH-1:0] fword_q, fword_d;
   logic [IDX_WIDTH-1:0]   idx_q, idx_d;
   logic                   done_q, done_d;
   logic [FWORD_WIDTH-1:0] f_start_q, f_start_d;
   logic [FWORD_WIDTH-1:0] f_step_q, f_step_d;
   logic [IDX_WIDTH-1:0]   n_pts_q, n_pts_d;
   logic [CNT_WIDTH-1:0]   settle_q, settle_d;
   logic [CNT_WIDTH-1:0]   dwell_q, dwell_d;
   logic                   cont_q, cont_d;
   logic                   last_pt;

   assign last_pt = (idx_q == n_pts_q - IDX_WIDTH'(1));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      fword_d   = fword_q;
      idx_d     = idx_q;
      done_d    = 1'b0;
      f_start_d = f_start_q;
      f_step_d  = f_step_q;
      n_pts_d   = n_pts_q;
      settle_d  = settle_q;
      dwell_d   = dwell_q;
      cont_d    = cont_q;
      case (state_q)
         S_IDLE: begin
            if (param_wen) begin
               f_start_d = f_start;
               f_step_d  = f_step;
               n_pts_d   = n_points;
               settle_d  = settle_cycles;
               dwell_d   = dwell_cycles;
               cont_d    = continuous;
            end
            // start uses the values latched before this cycle
            if (start && !abort && (n_pts_q != '0)) begin
               state_d = S_SETTLE;
               fword_d = f_start_q;
               idx_d   = '0;
               cnt_d   = settle_q;
            end
         end
         S_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = S_DWELL;
               cnt_d   = dwell_q;
            end else begin
               cnt_d = cnt_q - CNT_WIDTH'(1);
            end
         end
         S_DWELL: begin
            if (cnt_q == '0) state_d = S_WAIT;
            else             cnt_d   = cnt_q - CNT_WIDTH'(1);
         end
         S_WAIT: begin
            if (meas_ack) begin
               if (last_pt) begin
                  done_d = 1'b1;
                  if (cont_q) begin
                     state_d = S_SETTLE;
                     idx_d   = '0;
                     fword_d = f_start_q;
                     cnt_d   = settle_q;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  state_d = S_SETTLE;
                  idx_d   = idx_q + IDX_WIDTH'(1);
                  fword_d = fword_q + f_step_q;
                  cnt_d   = settle_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // abort overrides any transition, including ack and restart
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
         fword_d = fword_q;
         idx_d   = idx_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         fword_q   <= '0;
         idx_q     <= '0;
         done_q    <= 1'b0;
         f_start_q <= '0;
         f_step_q  <= '0;
         n_pts_q   <= '0;
         settle_q  <= '0;
         dwell_q   <= '0;
         cont_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         fword_q   <= fword_d;
         idx_q     <= idx_d;
         done_q    <= done_d;
         f_start_q <= f_start_d;
         f_step_q  <= f_step_d;
         n_pts_q   <= n_pts_d;
         settle_q  <= settle_d;
         dwell_q   <= dwell_d;
         cont_q    <= cont_d;
      end
   end

   assign fword      = fword_q;
   assign point_idx  = idx_q;
   assign busy       = (state_q != S_IDLE);
   assign meas_valid = (state_q == S_DWELL);
   assign point_rdy  = (state_q == S_WAIT);
   assign sweep_done = done_q;

endmodule
